// File: rtl/temp_conv_pkg.sv
// Shared types and constants for the sequential Celsius/Fahrenheit converter.
package temp_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        FMT_C2F = 1'b0,
        FMT_F2C = 1'b1
    } fmt_e;

    localparam int F_OFFSET  = 32;
    localparam int C2F_MUL   = 9;
    localparam int C2F_DIV   = 5;
    localparam int F2C_MUL   = 5;
    localparam int F2C_DIV   = 9;
    // Half the divisor rounded down; added before dividing to round to nearest.
    localparam int C2F_ROUND = 2;
    localparam int F2C_ROUND = 4;
    localparam int DVS_W     = 4;
    localparam int MAX_DW    = 20;

    function automatic logic [MAX_DW-1:0] mul_shift_add(input logic [MAX_DW-1:0] x,
                                                        input logic [DVS_W-1:0]  k);
        logic [MAX_DW-1:0] acc;
        acc = '0;
        for (int b = 0; b < DVS_W; b++) begin
            if (k[b]) begin
                acc = acc + (x << b);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/serial_div.sv
// Restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles after start.
module serial_div
    import temp_conv_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DVW   = DVS_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [DVW-1:0]   divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [DVW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [DVW-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DVW:0]     shifted_s;
    logic [DVW:0]     diff_s;

    // Divider state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    // Load on start, otherwise retire one restoring step while bits remain
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        shifted_s = {rem_q, quo_q[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvs_q};
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            if (shifted_s >= {1'b0, dvs_q}) begin
                rem_d = DVW'(diff_s);
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = DVW'(shifted_s);
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // High during the cycle whose rising edge retires the final quotient bit
    assign done_o     = (cnt_q == CW'(1));
    assign quotient_o = quo_q;

endmodule

// File: rtl/temp_conv_seq.sv
// Sequential temperature converter: C->F or F->C with rounding, saturation and
// a valid/ready handshake on both sides; divides serially by 5 or 9.
module temp_conv_seq
    import temp_conv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_temp,
    input  logic         i_format,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_temp,
    output logic         o_neg,
    output logic         o_sat
);

    localparam int DW = W + 4;

    state_e              state_q, state_d;
    fmt_e                fmt_q, fmt_d, fmt_in_s;
    logic                neg_q, neg_d, neg_in_s;
    logic [W-1:0]        temp_q, temp_d;
    logic                out_neg_q, out_neg_d;
    logic                sat_q, sat_d;
    logic                accept_s;
    logic                div_done_s;
    logic [MAX_DW-1:0]   temp_ext_s, mag_s;
    logic [DW-1:0]       dividend_s, quo_s, res_s;
    logic [DVS_W-1:0]    divisor_s;
    logic                sat_s;

    assign accept_s = i_valid && (state_q == ST_IDLE);
    assign fmt_in_s = fmt_e'(i_format);

    // Dividend/divisor for the incoming request; below 32 F the magnitude is mirrored
    always_comb begin
        temp_ext_s = MAX_DW'(i_temp);
        mag_s      = '0;
        neg_in_s   = 1'b0;
        if (fmt_in_s == FMT_C2F) begin
            dividend_s = DW'(mul_shift_add(temp_ext_s, DVS_W'(C2F_MUL)) + MAX_DW'(C2F_ROUND));
            divisor_s  = DVS_W'(C2F_DIV);
        end else begin
            if (temp_ext_s >= MAX_DW'(F_OFFSET)) begin
                mag_s = temp_ext_s - MAX_DW'(F_OFFSET);
            end else begin
                mag_s    = MAX_DW'(F_OFFSET) - temp_ext_s;
                neg_in_s = 1'b1;
            end
            dividend_s = DW'(mul_shift_add(mag_s, DVS_W'(F2C_MUL)) + MAX_DW'(F2C_ROUND));
            divisor_s  = DVS_W'(F2C_DIV);
        end
    end

    serial_div #(
        .WIDTH (DW),
        .DVW   (DVS_W)
    ) u_div (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .start_i    (accept_s),
        .dividend_i (dividend_s),
        .divisor_i  (divisor_s),
        .quotient_o (quo_s),
        .done_o     (div_done_s)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = i_valid    ? ST_DIV  : ST_IDLE;
            ST_DIV:  state_d = div_done_s ? ST_FIN  : ST_DIV;
            ST_FIN:  state_d = ST_DONE;
            ST_DONE: state_d = i_ready    ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM handshake outputs decoded from the state register
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            ST_IDLE: o_ready = 1'b1;
            ST_DONE: o_valid = 1'b1;
            default: begin
                o_ready = 1'b0;
                o_valid = 1'b0;
            end
        endcase
    end

    // Final result: add the Fahrenheit offset for C->F and clamp to W bits
    always_comb begin
        res_s = (fmt_q == FMT_C2F) ? (quo_s + DW'(F_OFFSET)) : quo_s;
        sat_s = (res_s[DW-1:W] != '0);
    end

    // Request capture on acceptance and result capture in FIN
    always_comb begin
        fmt_d     = fmt_q;
        neg_d     = neg_q;
        temp_d    = temp_q;
        out_neg_d = out_neg_q;
        sat_d     = sat_q;
        if (accept_s) begin
            fmt_d = fmt_in_s;
            neg_d = neg_in_s;
        end else if (state_q == ST_FIN) begin
            temp_d    = sat_s ? {W{1'b1}} : res_s[W-1:0];
            out_neg_d = neg_q;
            sat_d     = sat_s;
        end else begin
            fmt_d = fmt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fmt_q     <= FMT_C2F;
            neg_q     <= 1'b0;
            temp_q    <= '0;
            out_neg_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            fmt_q     <= fmt_d;
            neg_q     <= neg_d;
            temp_q    <= temp_d;
            out_neg_q <= out_neg_d;
            sat_q     <= sat_d;
        end
    end

    assign o_temp = temp_q;
    assign o_neg  = out_neg_q;
    assign o_sat  = sat_q;

endmodule

// File: tb/tb_temp_conv_seq.sv
// Directed and exhaustive self-checking bench for temp_conv_seq at W=8.
module tb_temp_conv_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready;
    logic [W-1:0] in_temp = '0;
    logic         in_format = 1'b0;
    logic         out_valid;
    logic         in_ready = 1'b0;
    logic [W-1:0] out_temp;
    logic         out_neg;
    logic         out_sat;

    int err_cnt = 0;
    int chk_cnt = 0;

    temp_conv_seq #(.W(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_temp   (in_temp),
        .i_format (in_format),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_temp   (out_temp),
        .o_neg    (out_neg),
        .o_sat    (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Nearest-integer reference; no ties exist for either direction.
    function automatic void model(input int t, input bit f, output int r, output bit n, output bit s);
        n = 1'b0;
        if (!f) begin
            r = (18 * t + 5) / 10 + 32;
        end else if (t >= 32) begin
            r = (10 * (t - 32) + 9) / 18;
        end else begin
            r = (10 * (32 - t) + 9) / 18;
            n = 1'b1;
        end
        s = (r > 255);
        if (s) r = 255;
    endfunction

    // Present a request at the current negedge; return cycles from acceptance to o_valid.
    task automatic do_req(input int t, input bit f, output int lat);
        in_temp   = t[W-1:0];
        in_format = f;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_temp   = 8'hA5;
        in_format = ~f;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_res();
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
    endtask

    task automatic run_dir(input string tag, input int t, input bit f,
                           input int et, input bit en, input bit es);
        int lat;
        chk({tag, "_rdy"}, out_ready, 1);
        do_req(t, f, lat);
        chk({tag, "_lat"}, lat, W + 5);
        chk({tag, "_temp"}, out_temp, et);
        chk({tag, "_neg"}, out_neg, en);
        chk({tag, "_sat"}, out_sat, es);
        release_res();
        chk({tag, "_idle"}, out_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, et, hold;
        bit  en, es, stable, seen;

        repeat (3) @(negedge clk);
        chk("rst_ready", out_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_temp", out_temp, 0);
        chk("rst_neg", out_neg, 0);
        chk("rst_sat", out_sat, 0);
        rst = 1'b0;

        run_dir("c2f_100", 100, 1'b0, 212, 1'b0, 1'b0);
        run_dir("c2f_1",     1, 1'b0,  34, 1'b0, 1'b0);
        run_dir("c2f_0",     0, 1'b0,  32, 1'b0, 1'b0);
        run_dir("f2c_212", 212, 1'b1, 100, 1'b0, 1'b0);
        run_dir("f2c_255", 255, 1'b1, 124, 1'b0, 1'b0);
        run_dir("f2c_32",   32, 1'b1,   0, 1'b0, 1'b0);
        run_dir("f2c_31",   31, 1'b1,   1, 1'b1, 1'b0);
        run_dir("f2c_0",     0, 1'b1,  18, 1'b1, 1'b0);
        run_dir("c2f_200", 200, 1'b0, 255, 1'b0, 1'b1);

        // Backpressure: hold i_ready low, fire a second request that must be ignored.
        do_req(100, 1'b0, lat);
        chk("bp_lat", lat, W + 5);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                in_valid  = 1'b1;
                in_temp   = 8'd50;
                in_format = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!(out_valid && !out_ready && out_temp == 8'd212 && !out_neg && !out_sat))
                stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_stable", stable, 1);
        release_res();
        chk("bp_ready", out_ready, 1);
        chk("bp_valid", out_valid, 0);
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("bp_no_ghost", seen, 0);
        chk("bp_hold_temp", out_temp, 212);

        // Reset five cycles after acceptance, with i_valid high during reset.
        in_temp   = 8'd100;
        in_format = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_temp  = 8'd0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rm_ready", out_ready, 1);
        chk("rm_valid", out_valid, 0);
        chk("rm_temp", out_temp, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rm_no_valid", seen, 0);
        run_dir("rm_next", 100, 1'b0, 212, 1'b0, 1'b0);

        // Every input in both directions with a random consumer stall.
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 256; t++) begin
                string tag;
                tag = $sformatf("exh_%s_%0d", (f != 0) ? "f2c" : "c2f", t);
                model(t, f != 0, et, en, es);
                do_req(t, f != 0, lat);
                chk({tag, "_lat"}, lat, W + 5);
                chk({tag, "_temp"}, out_temp, et);
                chk({tag, "_neg"}, out_neg, en);
                chk({tag, "_sat"}, out_sat, es);
                hold = $urandom_range(0, 3);
                repeat (hold) @(negedge clk);
                chk({tag, "_hold_vld"}, out_valid, 1);
                chk({tag, "_hold_temp"}, out_temp, et);
                release_res();
                chk({tag, "_idle"}, out_ready, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/temp_conv_seq.md
TEMP_CONV_SEQ -- requirements
Module: temp_conv_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning temperature magnitude width in bits (legal range 4..16).
REQ-002 SHALL have port i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  request strobe; i_temp and i_format are valid.
REQ-005 SHALL have port o_ready  output  1  block can accept a request.
REQ-006 SHALL have port i_temp  input  W  unsigned input temperature, whole degrees.
REQ-007 SHALL have port i_format  input  1  0 = Celsius to Fahrenheit, 1 = Fahrenheit to Celsius.
REQ-008 SHALL have port o_valid  output  1  result valid.
REQ-009 SHALL have port i_ready  input  1  consumer accepts result.
REQ-010 SHALL have port o_temp  output  W  result magnitude, unsigned.
REQ-011 SHALL have port o_neg  output  1  result is negative (F-to-C only).
REQ-012 SHALL have port o_sat  output  1  true result exceeded 2^W-1; o_temp clamped.

Function
REQ-013 SHALL implement FSM states IDLE, DIV, FIN, DONE.
REQ-014 SHALL assert o_ready only in IDLE; acceptance is i_valid && o_ready at a rising edge.
- Acceptance captures i_temp and i_format; later changes are ignored until the next acceptance.
- Acceptance moves IDLE to DIV.
REQ-015 SHALL form the C-to-F dividend as i_temp*9+2 with divisor 5.
REQ-016 SHALL form the F-to-C dividend as follows, with divisor 9:
- i_temp >= 32: (i_temp-32)*5+4.
- i_temp < 32: (32-i_temp)*5+4, with o_neg = 1.
REQ-017 SHALL size the dividend W+4 bits and form it with shift-add only, no generic multiplier.
REQ-018 SHALL divide by restoring division, one quotient bit per cycle, MSB first, for exactly W+4 cycles in DIV, then move to FIN.
REQ-019 SHALL, in FIN (one cycle), compute the result, register it to o_temp/o_neg/o_sat, and move to DONE.
- C-to-F: add 32 to the quotient.
- F-to-C: result is the quotient.
- Saturate to 2^W-1 with o_sat = 1 if the result exceeds 2^W-1.
REQ-020 SHALL assert o_valid exactly W+5 cycles after the acceptance edge (W=8: 13 cycles).
REQ-021 SHALL hold o_valid, o_temp, o_neg and o_sat stable in DONE until i_valid... rather, until i_ready is sampled high, then return to IDLE.
- A new request is accepted no earlier than the cycle after return to IDLE.
REQ-022 SHALL produce o_neg = 0 and o_sat = 0 for all C-to-F requests.
REQ-023 SHALL give o_neg = 0 for F-to-C input exactly 32, so result 0 is never reported as negative.
REQ-024 SHALL keep o_temp, o_neg, o_sat at their last values outside DONE; only o_valid qualifies them.

Reset
REQ-025 SHALL, on i_rst high at a rising edge, set the following, including mid-DIV/FIN/DONE (operation aborted, no o_valid produced):
- state = IDLE, o_ready = 1, o_valid = 0.
- o_temp = 0, o_neg = 0, o_sat = 0.
- Divider registers = 0.
REQ-026 SHALL ignore i_valid in any cycle where i_rst is high.

Structure
REQ-027 SHALL take the following from shared package temp_conv_pkg:
- FSM state enum.
- Format enum (FMT_C2F, FMT_F2C).
- Constants F_OFFSET = 32, C2F_MUL = 9, C2F_DIV = 5, F2C_MUL = 5, F2C_DIV = 9.
REQ-028 SHALL place the serial restoring divider in one sub-module, serial_div (parametrised width, start/done), instantiated once.

Verification (W=8)
REQ-029 SHALL cover C-to-F, one case each:
- i_temp=100 -> o_temp=212, o_neg=0, o_sat=0, o_valid 13 cycles after acceptance.
- i_temp=1 -> 34 (33.8 rounded).
- i_temp=0 -> 32.
REQ-030 SHALL cover F-to-C, one case each:
- i_temp=212 -> 100.
- i_temp=255 -> 124.
- i_temp=32 -> 0, o_neg=0.
- i_temp=31 -> 1, o_neg=1.
- i_temp=0 -> 18, o_neg=1.
REQ-031 SHALL cover saturation: C-to-F i_temp=200 -> o_temp=255, o_sat=1.
REQ-032 SHALL cover backpressure: i_ready held low 20 cycles after o_valid -> outputs stable, o_ready=0, second i_valid ignored; i_ready high -> IDLE next cycle.
REQ-033 SHALL cover reset mid-DIV: i_rst at cycle 5 after acceptance -> o_valid never asserts, o_ready=1 next cycle, next request 100 C-to-F -> 212.
REQ-034 SHALL cover the exhaustive check: all 256 inputs x both formats, random i_ready, versus a rounded reference model.
